// File: rtl/step_seq_ctrl.sv
// Step/direction sequencer: counted or homing moves with direction setup, period shaping and abort.
// Optional macro STEP_LIMIT_STOP_EN stops dir=0 count moves at the home/limit switch.
module step_seq_ctrl #(
    parameter int CNT_W     = 16,
    parameter int PER_W     = 16,
    parameter int DIR_SETUP = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             cmd_home,
    input  logic             homed,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] HIGH  = 2'd2;
    localparam logic [1:0] LOW   = 2'd3;

    localparam logic [1:0] ST_COUNT = 2'b00;
    localparam logic [1:0] ST_HOMED = 2'b01;
    localparam logic [1:0] ST_ABORT = 2'b10;
    localparam logic [1:0] ST_LIMIT = 2'b11;

    // DIR_SETUP is expected to be at least 1.
    localparam logic [PER_W-1:0] SETUP_TERM = PER_W'(DIR_SETUP - 1);
    localparam logic [PER_W-1:0] PER_ONE    = PER_W'(1);
    localparam logic [PER_W-1:0] PER_MIN    = PER_W'(2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             home_mode_q, home_mode_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             step_q, step_d;
    logic             done_q, done_d;
    logic [1:0]       status_q, status_d;
    logic             sync1_q, home_s_q;

    logic [PER_W-1:0] hi_term, lo_term;
    logic             try_high, home_hit, limit_hit;

    assign hi_term  = (per_q >> 1) - PER_ONE;
    assign lo_term  = per_q - (per_q >> 1) - PER_ONE;
    assign home_hit = home_mode_q & home_s_q;

`ifdef STEP_LIMIT_STOP_EN
    assign limit_hit = ~home_mode_q & ~dir_q & home_s_q;
`else
    assign limit_hit = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE) && !done_q;
    assign busy      = (state_q != IDLE);
    assign step      = step_q;
    assign dir       = dir_q;
    assign done      = done_q;
    assign status    = status_q;
    assign remaining = rem_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        per_d       = per_q;
        home_mode_d = home_mode_q;
        dir_d       = dir_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        status_d    = status_q;
        try_high    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    dir_d       = cmd_dir;
                    rem_d       = cmd_home ? '0 : cmd_steps;
                    per_d       = (cmd_period < PER_MIN) ? PER_MIN : cmd_period;
                    home_mode_d = cmd_home;
                    cnt_d       = '0;
                    if (!cmd_home && (cmd_steps == '0)) begin
                        done_d   = 1'b1;
                        status_d = ST_COUNT;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_TERM) try_high = 1'b1;
                else cnt_d = cnt_q + PER_ONE;
            end
            HIGH: begin
                if (cnt_q == hi_term) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PER_ONE;
                end
            end
            default: begin
                if (cnt_q == lo_term) begin
                    if (!home_mode_q) begin
                        rem_d = (rem_q == '0) ? '0 : rem_q - CNT_ONE;
                        if (rem_q <= CNT_ONE) begin
                            state_d  = IDLE;
                            done_d   = 1'b1;
                            status_d = ST_COUNT;
                        end else begin
                            try_high = 1'b1;
                        end
                    end else begin
                        try_high = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + PER_ONE;
                end
            end
        endcase

        // The switch is checked on every HIGH entry, so a stop never emits a partial pulse.
        if (try_high) begin
            cnt_d = '0;
            if (home_hit) begin
                state_d  = IDLE;
                done_d   = 1'b1;
                status_d = ST_HOMED;
            end else if (limit_hit) begin
                state_d  = IDLE;
                done_d   = 1'b1;
                status_d = ST_LIMIT;
            end else begin
                state_d = HIGH;
            end
        end

        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            rem_d    = rem_q;
            done_d   = 1'b1;
            status_d = ST_ABORT;
        end
    end

    assign step_d = (state_d == HIGH);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            per_q       <= PER_MIN;
            home_mode_q <= 1'b0;
            dir_q       <= 1'b0;
            rem_q       <= '0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= ST_COUNT;
            sync1_q     <= 1'b0;
            home_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            home_mode_q <= home_mode_d;
            dir_q       <= dir_d;
            rem_q       <= rem_d;
            step_q      <= step_d;
            done_q      <= done_d;
            status_q    <= status_d;
            sync1_q     <= homed;
            home_s_q    <= sync1_q;
        end
    end

endmodule

// File: tb/tb_step_seq_ctrl.sv
// Directed bench for step_seq_ctrl; expectations follow STEP_LIMIT_STOP_EN when it is defined.
module tb_step_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_dir, cmd_home, homed, abort;
    logic [15:0] cmd_steps, cmd_period, remaining;
    logic        step, dir, busy, done;
    logic [1:0]  status;

    int total = 0;
    int bad   = 0;

    int          w_first, w_done, w_pulses, w_hmin, w_hmax, w_lmin, w_lmax, w_home_cyc;
    logic [1:0]  w_st;
    logic [15:0] w_rem;
    logic        w_step_done, w_busy_ok, w_ready_seen;

    step_seq_ctrl #(.CNT_W(16), .PER_W(16), .DIR_SETUP(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .cmd_home   (cmd_home),
        .homed      (homed),
        .abort      (abort),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .remaining  (remaining)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic d, input logic [15:0] n, input logic [15:0] p,
                         input logic h);
        int g;
        @(negedge clock);
        cmd_dir    = d;
        cmd_steps  = n;
        cmd_period = p;
        cmd_home   = h;
        cmd_valid  = 1'b1;
        g = 0;
        while (!cmd_ready && g < 50) begin
            @(negedge clock);
            g++;
        end
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    // Cycle k is the k-th negedge after the acceptance edge.
    task automatic watch(input int max_cyc, input int home_at, input int abort_at);
        int   hi_run, lo_run;
        logic prev;
        w_first = 0; w_done = 0; w_pulses = 0; w_home_cyc = 0;
        w_hmin = 9999; w_hmax = 0; w_lmin = 9999; w_lmax = 0;
        w_busy_ok = 1'b1; w_ready_seen = 1'b0; w_st = 2'bxx; w_rem = 'x; w_step_done = 1'bx;
        prev = 1'b0; hi_run = 0; lo_run = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clock);
            if (abort) abort = 1'b0;
            if (done) begin
                w_done = k; w_st = status; w_rem = remaining; w_step_done = step;
                if (lo_run > 0) begin
                    if (lo_run < w_lmin) w_lmin = lo_run;
                    if (lo_run > w_lmax) w_lmax = lo_run;
                end
                break;
            end
            if (!busy) w_busy_ok = 1'b0;
            if (cmd_ready) w_ready_seen = 1'b1;
            if (step) begin
                if (!prev) begin
                    w_pulses++;
                    if (w_first == 0) w_first = k;
                    if (lo_run > 0) begin
                        if (lo_run < w_lmin) w_lmin = lo_run;
                        if (lo_run > w_lmax) w_lmax = lo_run;
                    end
                    lo_run = 0;
                    if (w_pulses == home_at) begin homed = 1'b1; w_home_cyc = k; end
                    if (w_pulses == abort_at) abort = 1'b1;
                end
                hi_run++;
            end else begin
                if (prev) begin
                    if (hi_run < w_hmin) w_hmin = hi_run;
                    if (hi_run > w_hmax) w_hmax = hi_run;
                    hi_run = 0;
                end
                if (w_pulses > 0) lo_run++;
            end
            prev = step;
        end
    endtask

    initial begin
        int g;
        reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; cmd_period = '0;
        cmd_home = 1'b0; homed = 1'b0; abort = 1'b0;
        #12;
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_remaining", remaining, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", cmd_ready, 1);

        // Basic count move: 3 steps, period 10, dir 1.
        issue(1'b1, 16'd3, 16'd10, 1'b0);
        watch(100, 0, 0);
        chk("cnt3_first_step_cyc", w_first, 9);
        chk("cnt3_pulses", w_pulses, 3);
        chk("cnt3_high_min", w_hmin, 5);
        chk("cnt3_high_max", w_hmax, 5);
        chk("cnt3_low_min", w_lmin, 5);
        chk("cnt3_low_max", w_lmax, 5);
        chk("cnt3_done_cyc", w_done, 39);
        chk("cnt3_status", w_st, 0);
        chk("cnt3_remaining", w_rem, 0);
        chk("cnt3_busy_during", w_busy_ok, 1);
        chk("cnt3_ready_during", w_ready_seen, 0);
        chk("cnt3_dir", dir, 1);

        // Period clamping: 1 and 0 both behave as period 2.
        issue(1'b1, 16'd2, 16'd1, 1'b0);
        watch(100, 0, 0);
        chk("p1_pulses", w_pulses, 2);
        chk("p1_high", w_hmax, 1);
        chk("p1_low", w_lmax, 1);
        chk("p1_done_cyc", w_done, 13);
        issue(1'b1, 16'd2, 16'd0, 1'b0);
        watch(100, 0, 0);
        chk("p0_pulses", w_pulses, 2);
        chk("p0_high", w_hmin, 1);
        chk("p0_low", w_lmin, 1);
        chk("p0_done_cyc", w_done, 13);

        // Zero-step command: done next cycle, no motion, dir still updated.
        issue(1'b0, 16'd0, 16'd10, 1'b0);
        watch(10, 0, 0);
        chk("z_done_cyc", w_done, 1);
        chk("z_status", w_st, 0);
        chk("z_pulses", w_pulses, 0);
        chk("z_busy", busy, 0);
        chk("z_ready_in_done", cmd_ready, 0);
        chk("z_dir", dir, 0);

        // Homing: switch raised after the 5th pulse.
        repeat (3) @(negedge clock);
        issue(1'b0, 16'd77, 16'd4, 1'b1);
        watch(200, 5, 0);
        chk("home_status", w_st, 1);
        chk("home_pulses", w_pulses, 5);
        chk("home_remaining", w_rem, 0);
        chk("home_latency_ok", (w_done > w_home_cyc) && (w_done - w_home_cyc <= 6), 1);
        // Switch already active: no pulse at all.
        repeat (3) @(negedge clock);
        issue(1'b0, 16'd0, 16'd4, 1'b1);
        watch(50, 0, 0);
        chk("home0_done_cyc", w_done, 9);
        chk("home0_status", w_st, 1);
        chk("home0_pulses", w_pulses, 0);
        homed = 1'b0;
        repeat (4) @(negedge clock);

        // Abort during the 10th HIGH of a 100-step move.
        issue(1'b1, 16'd100, 16'd10, 1'b0);
        watch(300, 0, 10);
        chk("abort_status", w_st, 2);
        chk("abort_step", w_step_done, 0);
        chk("abort_remaining", w_rem, 91);
        chk("abort_pulses", w_pulses, 10);
        abort = 1'b1;
        @(negedge clock);
        chk("abort_idle_nodone", done, 0);
        abort = 1'b0;

        // Limit switch on a dir=0 count move.
        repeat (3) @(negedge clock);
        issue(1'b0, 16'd50, 16'd2, 1'b0);
        watch(300, 7, 0);
`ifdef STEP_LIMIT_STOP_EN
        chk("limit_status", w_st, 3);
        chk("limit_pulses", w_pulses, 8);
        chk("limit_remaining", w_rem, 42);
`else
        chk("limit_status", w_st, 0);
        chk("limit_pulses", w_pulses, 50);
        chk("limit_remaining", w_rem, 0);
`endif
        homed = 1'b0;
        repeat (4) @(negedge clock);

        // cmd_valid held through a move: no acceptance until after the done cycle.
        @(negedge clock);
        cmd_dir = 1'b1; cmd_steps = 16'd1; cmd_period = 16'd2; cmd_home = 1'b0;
        cmd_valid = 1'b1;
        watch(60, 0, 0);
        chk("hold_done_cyc", w_done, 11);
        chk("hold_ready_during", w_ready_seen, 0);
        chk("hold_ready_in_done", cmd_ready, 0);
        @(negedge clock);
        chk("hold_ready_after", cmd_ready, 1);
        @(negedge clock);
        chk("hold_reaccept", busy, 1);
        cmd_valid = 1'b0;
        abort = 1'b1;
        watch(10, 0, 0);
        chk("hold_abort_status", w_st, 2);

        // Asynchronous reset in the middle of a pulse.
        repeat (3) @(negedge clock);
        issue(1'b1, 16'd5, 16'd10, 1'b0);
        g = 0;
        while (!step && g < 40) begin
            @(negedge clock);
            g++;
        end
        chk("mid_step_seen", step, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_step", step, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_remaining", remaining, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_nodone", done, 0);
        chk("mid_rst_ready", cmd_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
